// File: rtl/post_adder_norm_pkg.sv
// Shared FPAU mantissa-path constants and a width helper for the post-adder and rounder.
package post_adder_norm_pkg;

  localparam int FPAU_MANT_W = 23;               // stored fraction bits
  localparam int FPAU_SIG_W  = FPAU_MANT_W + 1;  // with hidden bit
  localparam int FPAU_ADD_W  = FPAU_SIG_W + 2;   // adder result: carry + sign
  localparam int WIDTH_DEF   = FPAU_ADD_W;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/post_adder_norm_lzc_tree.sv
// Combinational leading-zero counter; all-zero input returns WIDTH.
// Zero latency, no flow control.
module lzc_tree
  import post_adder_norm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LZW   = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [LZW-1:0]   cnt
);

  // Later (higher) set bits override, leaving the count of the topmost one.
  always_comb begin
    cnt = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = LZW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/post_adder_norm.sv
// Two-stage sign/magnitude split with leading-zero count and optional left-normalise.
// Latency 2; stage 2 holds while out_ready=0, stage 1 takes one more word then stalls input.
module post_adder_norm
  import post_adder_norm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter bit NORM  = 1'b1,
  localparam int LZW  = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WIDTH-1:0] frac,
  output logic [LZW-1:0]   lzc,
  output logic             zero
);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic             s1_sign_q, s1_sign_d;
  logic [WIDTH-1:0] s1_mag_q, s1_mag_d;
  logic             s2_sign_q, s2_sign_d;
  logic [WIDTH-1:0] s2_frac_q, s2_frac_d;
  logic [LZW-1:0]   s2_lzc_q, s2_lzc_d;
  logic             s2_zero_q, s2_zero_d;
  logic             adv2, accept, load2;
  logic [LZW-1:0]   mag_lzc;

  lzc_tree #(.WIDTH(WIDTH), .LZW(LZW)) u_lzc (
    .din (s1_mag_q),
    .cnt (mag_lzc)
  );

  always_comb begin
    adv2     = ~v2_q | out_ready;
    in_ready = ~v1_q | adv2;
    accept   = in_valid & in_ready;
    load2    = v1_q & adv2;
    v1_d     = accept | (v1_q & ~adv2);
    v2_d     = load2 | (v2_q & ~out_ready);

    s1_sign_d = s1_sign_q;
    s1_mag_d  = s1_mag_q;
    // Full-width negate keeps -2^(WIDTH-1) exact as 2^(WIDTH-1).
    if (accept) begin
      s1_sign_d = in[WIDTH-1];
      s1_mag_d  = in[WIDTH-1] ? (~in + WIDTH'(1)) : in;
    end

    s2_sign_d = s2_sign_q;
    s2_frac_d = s2_frac_q;
    s2_lzc_d  = s2_lzc_q;
    s2_zero_d = s2_zero_q;
    if (load2) begin
      s2_sign_d = s1_sign_q;
      s2_lzc_d  = mag_lzc;
      s2_zero_d = (s1_mag_q == '0);
      s2_frac_d = NORM ? (s1_mag_q << mag_lzc) : s1_mag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_frac_q <= '0;
      s2_lzc_q  <= '0;
      s2_zero_q <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s2_sign_q <= s2_sign_d;
      s2_frac_q <= s2_frac_d;
      s2_lzc_q  <= s2_lzc_d;
      s2_zero_q <= s2_zero_d;
    end
  end

  assign out_valid = v2_q;
  assign sign      = s2_sign_q;
  assign frac      = s2_frac_q;
  assign lzc       = s2_lzc_q;
  assign zero      = s2_zero_q;

endmodule

// File: tb/tb_post_adder_norm.sv
// Bench for post_adder_norm: WIDTH=26 NORM=1, WIDTH=26 NORM=0 and WIDTH=8 NORM=1 share one handshake.
module tb_post_adder_norm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [25:0] din;

  logic        ir_a, ov_a, sg_a, zr_a;
  logic [25:0] fr_a;
  logic [4:0]  lz_a;
  logic        ir_b, ov_b, sg_b, zr_b;
  logic [25:0] fr_b;
  logic [4:0]  lz_b;
  logic        ir_c, ov_c, sg_c, zr_c;
  logic [7:0]  fr_c;
  logic [3:0]  lz_c;

  post_adder_norm #(.WIDTH(26), .NORM(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in(din),
    .out_valid(ov_a), .out_ready(out_ready), .sign(sg_a), .frac(fr_a), .lzc(lz_a), .zero(zr_a));

  post_adder_norm #(.WIDTH(26), .NORM(1'b0)) u_dut_nonorm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in(din),
    .out_valid(ov_b), .out_ready(out_ready), .sign(sg_b), .frac(fr_b), .lzc(lz_b), .zero(zr_b));

  post_adder_norm #(.WIDTH(8), .NORM(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .in(din[7:0]),
    .out_valid(ov_c), .out_ready(out_ready), .sign(sg_c), .frac(fr_c), .lzc(lz_c), .zero(zr_c));

  typedef struct {
    logic [25:0] d;
    int          stamp;
  } item_t;

  item_t       q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [25:0] cap_fa[$];
  logic [25:0] cap_fb[$];
  logic [7:0]  cap_fc[$];
  int          cap_la[$];
  int          cap_lb[$];
  int          cap_lc[$];
  logic        cap_sa[$];
  logic        cap_za[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: sign, exact magnitude, leading zeros and normalised fraction by plain arithmetic.
  function automatic void ref_fn(input int w, input bit norm, input logic [25:0] x,
                                 output logic s, output logic [25:0] f, output int lz,
                                 output logic z);
    longint unsigned m;
    m  = longint'(x) & ((64'd1 << w) - 1);
    s  = ((m >> (w - 1)) & 1) != 0;
    if (s) m = (64'd1 << w) - m;
    z  = (m == 0);
    lz = 0;
    while (lz < w && ((m >> (w - 1 - lz)) & 1) == 0) lz++;
    if (norm && !z) m = m << lz;
    f = m[25:0];
  endfunction

  task automatic check_outputs(output logic exp_ov);
    logic        s, z;
    logic [25:0] f;
    int          lz;
    exp_ov = (q.size() > 0) && (cyc >= q[0].stamp + 1);
    chk("ov_a", ov_a, exp_ov);
    chk("ov_b", ov_b, exp_ov);
    chk("ov_c", ov_c, exp_ov);
    if (exp_ov) begin
      ref_fn(26, 1'b1, q[0].d, s, f, lz, z);
      chk("a_sign", sg_a, s);
      chk("a_frac", fr_a, f);
      chk("a_lzc", lz_a, lz);
      chk("a_zero", zr_a, z);
      ref_fn(26, 1'b0, q[0].d, s, f, lz, z);
      chk("b_sign", sg_b, s);
      chk("b_frac", fr_b, f);
      chk("b_lzc", lz_b, lz);
      chk("b_zero", zr_b, z);
      ref_fn(8, 1'b1, q[0].d, s, f, lz, z);
      chk("c_sign", sg_c, s);
      chk("c_frac", fr_c, f[7:0]);
      chk("c_lzc", lz_c, lz);
      chk("c_zero", zr_c, z);
    end
  endtask

  // One clock: check at negedge, drive, then advance the model for the coming posedge.
  task automatic step(input logic iv, input logic [25:0] d, input logic ordy,
                      output logic acc, output logic rdy);
    logic exp_ov, exp_ir;
    @(negedge clk);
    check_outputs(exp_ov);
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    chk("ir_a", ir_a, exp_ir);
    chk("ir_b", ir_b, exp_ir);
    chk("ir_c", ir_c, exp_ir);
    rdy = exp_ir;
    if (exp_ov && ordy) begin
      cap_fa.push_back(fr_a);
      cap_fb.push_back(fr_b);
      cap_fc.push_back(fr_c);
      cap_la.push_back(int'(lz_a));
      cap_lb.push_back(int'(lz_b));
      cap_lc.push_back(int'(lz_c));
      cap_sa.push_back(sg_a);
      cap_za.push_back(zr_a);
      void'(q.pop_front());
    end
    acc = iv && exp_ir;
    if (acc) q.push_back('{d: d, stamp: cyc + 1});
    cyc++;
  endtask

  function automatic logic [25:0] rand_word();
    logic [25:0] r;
    case ($urandom_range(0, 7))
      0: r = 26'h2000000;
      1: r = 26'h0000000;
      2: r = 26'h0000080;
      3: r = -26'($urandom_range(1, 16));
      4: r = 26'($urandom_range(0, 300));
      default: r = 26'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    logic        acc, rdy, saw_stall;
    logic [25:0] words[8];
    int          w, base;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    #1;
    chk("rst_ov", ov_a, 1'b0);
    chk("rst_sign", sg_a, 1'b0);
    chk("rst_frac", fr_a, 26'h0);
    chk("rst_lzc", lz_a, 5'd0);
    chk("rst_zero", zr_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed words with out_ready high.
    step(1'b1, 26'h3FFFFFF, 1'b1, acc, rdy);
    step(1'b1, 26'h2000000, 1'b1, acc, rdy);
    step(1'b1, 26'h0000000, 1'b1, acc, rdy);
    step(1'b1, 26'h0000005, 1'b1, acc, rdy);
    repeat (3) step(1'b0, 26'h0, 1'b1, acc, rdy);
    chk("dir_count", cap_fa.size(), 4);
    if (cap_fa.size() >= 4) begin
      chk("lit0_sign", cap_sa[0], 1'b1);
      chk("lit0_lzc", cap_la[0], 25);
      chk("lit0_frac", cap_fa[0], 26'h2000000);
      chk("lit0_zero", cap_za[0], 1'b0);
      chk("lit0_c_frac", cap_fc[0], 8'h80);
      chk("lit0_c_lzc", cap_lc[0], 7);
      chk("lit1_sign", cap_sa[1], 1'b1);
      chk("lit1_lzc", cap_la[1], 0);
      chk("lit1_frac", cap_fa[1], 26'h2000000);
      chk("lit1_nonorm_frac", cap_fb[1], 26'h2000000);
      chk("lit2_sign", cap_sa[2], 1'b0);
      chk("lit2_zero", cap_za[2], 1'b1);
      chk("lit2_lzc", cap_la[2], 26);
      chk("lit2_frac", cap_fa[2], 26'h0);
      chk("lit3_nonorm_frac", cap_fb[3], 26'h5);
      chk("lit3_nonorm_lzc", cap_lb[3], 23);
      chk("lit3_c_frac", cap_fc[3], 8'hA0);
    end

    // Eight back-to-back words, out_ready low for cycles 3..6.
    for (int i = 0; i < 8; i++) words[i] = rand_word();
    base = cap_fa.size();
    w = 0;
    saw_stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(w < 8, (w < 8) ? words[w] : 26'h0, !(i >= 3 && i <= 6), acc, rdy);
      if (!rdy) saw_stall = 1'b1;
      if (acc) w++;
    end
    chk("stream_accepted", w, 8);
    chk("stream_emitted", cap_fa.size() - base, 8);
    chk("stream_stalled", saw_stall, 1'b1);

    // Async reset with both stages full.
    step(1'b1, 26'h1234567, 1'b0, acc, rdy);
    step(1'b1, 26'h3ABCDEF, 1'b0, acc, rdy);
    step(1'b0, 26'h0, 1'b0, acc, rdy);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov_a", ov_a, 1'b0);
    chk("arst_ov_c", ov_c, 1'b0);
    chk("arst_frac", fr_a, 26'h0);
    chk("arst_lzc", lz_a, 5'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ov", ov_a, 1'b0);
    repeat (3) step(1'b0, 26'h0, 1'b0, acc, rdy);

    // Random traffic with random backpressure.
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 9) < 6, acc, rdy);
    repeat (5) step(1'b0, 26'h0, 1'b1, acc, rdy);
    chk("drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
